stdp_learn_ctrl: RTL and testbench
==================================

# stdp_learn_ctrl

Learning scheduler for the STDP neuron. It tracks pre-synaptic (input) and post-synaptic (spike_out) timing with per-input decaying traces. It turns coincident events into potentiate/depress requests and serializes them onto a single weight-update port with a valid/ready handshake. It sits beside the neuron in the top level, fed by `ui_in` and `spike_out`, and drives the neuron's weight-update interface.

## Interface
- `TICK_DIV`, 24'd10_000: clocks per trace-decay tick (≥2).
- `TRACE_W`, 4: trace counter width.
- `TRACE_MAX`, 4'd15: trace load value on a spike (nonzero, fits TRACE_W).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `learn`  in  1  1 = record new learning events.
- `pre_spike`  in  8  per-input spike pulses (same bits as neuron inputs).
- `post_spike`  in  1  neuron spike_out.
- `upd_ready`  in  1  weight-update sink accepts.
- `upd_valid`  out  1  update request valid.
- `upd_idx`  out  3  synapse index.
- `upd_dir`  out  1  1 = potentiate, 0 = depress.
- `busy`  out  1  any pending bit set or upd_valid high.
- `merge_cnt`  out  8  saturating count of events merged into already-pending bits.

## Operation
- Prescaler 0..TICK_DIV-1; `tick` pulses for one cycle when count = TICK_DIV-1, then wraps to 0.
- Pre traces `ptr[i]`: load TRACE_MAX when pre_spike[i]=1. Otherwise decrement by 1 on tick if nonzero; saturate at 0. Load beats decrement.
- Post trace `qtr`: same rules, driven by post_spike (depression build only).
- Potentiation: post_spike=1 and learn=1 → set `pot_pend[i]` for every i with old `ptr[i]`≠0. Same-cycle pre_spike[i] uses the pre-load value.
- Depression: pre_spike[i]=1 and learn=1 and old `qtr`≠0 → set `dep_pend[i]`.
- Setting an already-set pending bit is a merge: merge_cnt += number of merged bits, saturating at 255.
- learn=0 blocks new pending bits only. Traces keep running, existing pending bits drain, and an in-flight request completes.
- FSM IDLE / ISSUE:
  - IDLE: if any pot_pend|dep_pend, grant the first index i searching upward from `rr_ptr` (mod 8). dir=1 if pot_pend[i], else 0. Register idx/dir, go to ISSUE.
  - ISSUE: upd_valid=1. On valid&ready, clear the granted pending bit, set rr_ptr=i+1 mod 8, return to IDLE.
- If both pending bits are set for index i, potentiation is issued first. Depression for i waits until the pointer comes round again.
- A pending bit that is re-set in the same cycle it is cleared by the transfer stays set and is not counted as a merge.

## Timing
- Reset values: upd_valid=0, upd_idx=0, upd_dir=0, busy=0, merge_cnt=0. Traces, pending bits, rr_ptr, prescaler and FSM are all cleared.
- Asserting rst_n mid-transfer drops upd_valid immediately (asynchronous). The lost request is not replayed.
- Event latency: spike sampled at edge k → pending bit set after edge k, upd_valid high after edge k+1.
- Handshake: upd_idx/upd_dir stay stable while upd_valid=1 and upd_ready=0. upd_valid never drops without a transfer (except reset).
- Throughput: one IDLE bubble after each transfer, so at most 1 update per 2 cycles.
- Trace lifetime: after a load, the trace is nonzero for the next TRACE_MAX-1 full ticks plus the partial one. Exactly TRACE_MAX ticks reach 0.
- busy is registered: high the cycle after the first pending bit sets; low the cycle after the last transfer with nothing pending.

## Configuration
- `STDP_DEPRESS_EN` defined: qtr and dep_pend are implemented; both directions are issued.
- Not defined: no post trace, dep_pend is constant 0, upd_dir is always 1. Pre spikes after a post spike produce no update.

## Test plan
Bench parameters: TICK_DIV=4, TRACE_MAX=15.
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release → still 0 until an event.
- Potentiation order: learn=1, upd_ready=1, pre_spike=8'h05, post_spike 3 cycles later → transfers idx0/dir1 then idx2/dir1, with one idle cycle between; busy then drops.
- Trace expiry: pre_spike[3], then post after 14 ticks → idx3/dir1. Repeat with post after 15 ticks → no upd_valid.
- Depression (macro on): post_spike, pre_spike=8'h02 two cycles later → idx1/dir0. With macro off → no upd_valid.
- Backpressure/merge: upd_ready=0, pre_spike[0], two post_spikes → upd_valid held with idx0/dir1 stable and merge_cnt=1. Raise ready → exactly one transfer.
- Round-robin and learn gate: pending on idx 6,1 after grant at idx5 → order 6 then 1. learn=0 with spikes → no new requests, but pending bits still drain.

Source files
------------

// File: rtl/stdp_learn_ctrl.sv
// STDP learning scheduler: decaying pre/post traces, pending-bit capture and round-robin weight-update issue.
// Optional macro STDP_DEPRESS_EN adds the post trace and depression requests.
module stdp_learn_ctrl #(
  parameter logic [23:0]        TICK_DIV  = 24'd10_000,
  parameter int unsigned        TRACE_W   = 32'd4,
  parameter logic [TRACE_W-1:0] TRACE_MAX = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       learn,
  input  logic [7:0] pre_spike,
  input  logic       post_spike,
  input  logic       upd_ready,
  output logic       upd_valid,
  output logic [2:0] upd_idx,
  output logic       upd_dir,
  output logic       busy,
  output logic [7:0] merge_cnt
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [TRACE_W-1:0] TR_ZERO = {TRACE_W{1'b0}};
  localparam logic [TRACE_W-1:0] TR_ONE  = TRACE_W'(1);

  state_t                    state;
  logic [23:0]               pre_cnt;
  logic                      tick;
  logic [7:0][TRACE_W-1:0]   ptr;
  logic [7:0]                ptr_nz;
  logic [7:0]                pot_pend, dep_pend;
  logic [7:0]                pot_set, pot_clr, pot_keep, pot_next;
  logic [7:0]                pot_merge, dep_merge;
  logic [7:0]                req;
  logic [2:0]                rr_ptr, grant_idx, cand;
  logic                      grant_vld;
  logic                      xfer;
  logic [4:0]                merge_num;
  logic [8:0]                merge_sum;
  logic [7:0]                merge_next;

  assign tick = (pre_cnt == (TICK_DIV - 24'd1));
  assign xfer = upd_valid & upd_ready;
  assign req  = pot_pend | dep_pend;

  // Decay prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 24'd0;
    end else if (tick) begin
      pre_cnt <= 24'd0;
    end else begin
      pre_cnt <= pre_cnt + 24'd1;
    end
  end

  // Pre-synaptic traces: a spike reload beats the decay step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '{default: TR_ZERO};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pre_spike[i]) begin
          ptr[i] <= TRACE_MAX;
        end else if (tick && (ptr[i] != TR_ZERO)) begin
          ptr[i] <= ptr[i] - TR_ONE;
        end else begin
          ptr[i] <= ptr[i];
        end
      end
    end
  end

  // Trace liveness, sampled before this cycle's reload
  always_comb begin
    ptr_nz = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ptr_nz[i] = (ptr[i] != TR_ZERO);
    end
  end

`ifdef STDP_DEPRESS_EN
  logic [TRACE_W-1:0] qtr;
  logic [7:0]         dep_set, dep_clr, dep_keep, dep_next;

  // Post-synaptic trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qtr <= TR_ZERO;
    end else if (post_spike) begin
      qtr <= TRACE_MAX;
    end else if (tick && (qtr != TR_ZERO)) begin
      qtr <= qtr - TR_ONE;
    end else begin
      qtr <= qtr;
    end
  end

  // Depression capture: a bit cleared by this transfer and re-set is not a merge
  always_comb begin
    dep_set   = (learn && (qtr != TR_ZERO)) ? pre_spike : 8'h00;
    dep_clr   = (xfer && !upd_dir) ? (8'h01 << upd_idx) : 8'h00;
    dep_keep  = dep_pend & ~dep_clr;
    dep_next  = dep_keep | dep_set;
    dep_merge = dep_set & dep_keep;
  end

  // Depression pending bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep_pend <= 8'h00;
    end else begin
      dep_pend <= dep_next;
    end
  end
`else
  assign dep_pend  = 8'h00;
  assign dep_merge = 8'h00;
`endif

  // Potentiation capture and saturating merge accounting
  always_comb begin
    pot_set   = (learn && post_spike) ? ptr_nz : 8'h00;
    pot_clr   = (xfer && upd_dir) ? (8'h01 << upd_idx) : 8'h00;
    pot_keep  = pot_pend & ~pot_clr;
    pot_next  = pot_keep | pot_set;
    pot_merge = pot_set & pot_keep;
    merge_num = 5'd0;
    for (int k = 0; k < 8; k++) begin
      merge_num = merge_num + {4'd0, pot_merge[k]} + {4'd0, dep_merge[k]};
    end
    merge_sum  = {1'b0, merge_cnt} + {4'd0, merge_num};
    merge_next = merge_sum[8] ? 8'hFF : merge_sum[7:0];
  end

  // Round-robin search upward from rr_ptr; the lowest offset wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = rr_ptr + 3'(k);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

  // Pending bits, merge counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_pend  <= 8'h00;
      merge_cnt <= 8'h00;
      busy      <= 1'b0;
    end else begin
      pot_pend  <= pot_next;
      merge_cnt <= merge_next;
      busy      <= (|req) | upd_valid;
    end
  end

  // Issue FSM; potentiation wins when both directions are pending on one index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      upd_valid <= 1'b0;
      upd_idx   <= 3'd0;
      upd_dir   <= 1'b0;
      rr_ptr    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            upd_idx   <= grant_idx;
            upd_dir   <= pot_pend[grant_idx];
            upd_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            rr_ptr    <= upd_idx + 3'd1;
            state     <= IDLE;
          end
        end
        default: begin
          upd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdp_learn_ctrl.sv
// Self-checking bench for stdp_learn_ctrl: vector table, directed corner sequences and a
// randomized run against a time-based behavioural model.
module tb_stdp_learn_ctrl;

  localparam int TD   = 4;
  localparam int TMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       learn = 1'b0;
  logic [7:0] pre_spike = 8'h00;
  logic       post_spike = 1'b0;
  logic       upd_ready = 1'b0;
  logic       upd_valid;
  logic [2:0] upd_idx;
  logic       upd_dir;
  logic       busy;
  logic [7:0] merge_cnt;

  stdp_learn_ctrl #(
    .TICK_DIV (24'd4),
    .TRACE_W  (32'd4),
    .TRACE_MAX(4'd15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .learn     (learn),
    .pre_spike (pre_spike),
    .post_spike(post_spike),
    .upd_ready (upd_ready),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_dir   (upd_dir),
    .busy      (busy),
    .merge_cnt (merge_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (time-based traces) ----------------
  int   m_cyc, m_tcount;
  bit   m_loaded[8];
  int   m_load_t[8];
`ifdef STDP_DEPRESS_EN
  bit   m_qloaded;
  int   m_qload_t;
`endif
  bit [7:0] m_pot, m_dep;
  bit   m_valid, m_dir, m_busy;
  int   m_idx, m_rr, m_merge;

  function automatic bit live(input bit ld, input int t);
    return ld && ((m_tcount - t) < TMAX);
  endfunction

  task automatic m_reset();
    m_cyc = 0; m_tcount = 0;
    for (int i = 0; i < 8; i++) begin m_loaded[i] = 1'b0; m_load_t[i] = 0; end
`ifdef STDP_DEPRESS_EN
    m_qloaded = 1'b0; m_qload_t = 0;
`endif
    m_pot = 8'h00; m_dep = 8'h00;
    m_valid = 1'b0; m_dir = 1'b0; m_busy = 1'b0;
    m_idx = 0; m_rr = 0; m_merge = 0;
  endtask

  task automatic m_step(input logic l, input logic [7:0] p, input logic po, input logic r);
    bit [7:0] pn, dn;
    int merges, j;
    bit any_old, found;
    pn = m_pot; dn = m_dep; merges = 0;
    any_old = ((m_pot | m_dep) != 8'h00);
    if (m_valid && r) begin
      if (m_dir) pn[m_idx] = 1'b0;
      else       dn[m_idx] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (l && po && live(m_loaded[i], m_load_t[i])) begin
        if (pn[i]) merges++;
        pn[i] = 1'b1;
      end
    end
`ifdef STDP_DEPRESS_EN
    for (int i = 0; i < 8; i++) begin
      if (l && p[i] && live(m_qloaded, m_qload_t)) begin
        if (dn[i]) merges++;
        dn[i] = 1'b1;
      end
    end
`endif
    m_busy = any_old || m_valid;
    if (!m_valid) begin
      if (any_old) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          j = (m_rr + k) % 8;
          if (!found && (m_pot[j] || m_dep[j])) begin
            found = 1'b1;
            m_idx = j;
          end
        end
        m_dir = m_pot[m_idx];
        m_valid = 1'b1;
      end
    end else if (r) begin
      m_valid = 1'b0;
      m_rr = (m_idx + 1) % 8;
    end
    if ((m_cyc % TD) == TD - 1) m_tcount++;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin m_loaded[i] = 1'b1; m_load_t[i] = m_tcount; end
    end
`ifdef STDP_DEPRESS_EN
    if (po) begin m_qloaded = 1'b1; m_qload_t = m_tcount; end
`endif
    m_merge = (m_merge + merges > 255) ? 255 : m_merge + merges;
    m_pot = pn; m_dep = dn;
    m_cyc++;
  endtask

  task automatic mchk();
    chk("model_valid", upd_valid, m_valid);
    chk("model_idx",   upd_idx,   m_idx);
    chk("model_dir",   upd_dir,   m_dir);
    chk("model_busy",  busy,      m_busy);
    chk("model_merge", merge_cnt, m_merge);
  endtask

  // One clock: drive, log transfer, edge, advance model, compare
  task automatic cyc(input logic l, input logic [7:0] p, input logic po, input logic r);
    learn = l; pre_spike = p; post_spike = po; upd_ready = r;
    if (upd_valid && r) xq.push_back(int'(upd_idx) * 2 + int'(upd_dir));
    @(posedge clk);
    m_step(l, p, po, r);
    #1;
    mchk();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      learn = 1'($urandom); pre_spike = 8'($urandom);
      post_spike = 1'($urandom); upd_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_valid", upd_valid, 0);
      chk("rst_idx",   upd_idx,   0);
      chk("rst_dir",   upd_dir,   0);
      chk("rst_busy",  busy,      0);
      chk("rst_merge", merge_cnt, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    learn = 1'b0; pre_spike = 8'h00; post_spike = 1'b0; upd_ready = 1'b0;
    m_reset();
    xq.delete();
    #1;
    chk("rel_valid", upd_valid, 0);
    chk("rel_busy",  busy,      0);
  endtask

  typedef struct {
    logic       l;
    logic [7:0] pre;
    logic       post;
    logic       rdy;
    logic       ev;
    logic [2:0] ei;
    logic       ed;
    logic       eb;
  } vec_t;

  vec_t tbl[10];
  bit   seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Potentiation order: pre 8'h05, post three cycles later
    tbl[0] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    m_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].l, tbl[i].pre, tbl[i].post, tbl[i].rdy);
      chk("tbl_valid", upd_valid, tbl[i].ev);
      chk("tbl_busy",  busy,      tbl[i].eb);
      if (tbl[i].ev) begin
        chk("tbl_idx", upd_idx, tbl[i].ei);
        chk("tbl_dir", upd_dir, tbl[i].ed);
      end
    end

    // Trace expiry: post after 14 ticks still potentiates
    do_reset();
    cyc(1'b1, 8'h08, 1'b0, 1'b1);
    repeat (55) cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    chk("exp14_valid", upd_valid, 1);
    chk("exp14_idx",   upd_idx,   3);
    chk("exp14_dir",   upd_dir,   1);
    repeat (3) cyc(1'b1, 8'h00, 1'b0, 1'b1);

    // Trace expiry: post after 15 ticks does nothing
    do_reset();
    cyc(1'b1, 8'h08, 1'b0, 1'b1);
    repeat (59) cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, 8'h00, 1'b0, 1'b1);
      seen = seen | upd_valid;
    end
    chk("exp15_none", seen, 0);

    // Depression: post, then pre 8'h02 two cycles later
    do_reset();
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h02, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
`ifdef STDP_DEPRESS_EN
    chk("dep_valid", upd_valid, 1);
    chk("dep_idx",   upd_idx,   1);
    chk("dep_dir",   upd_dir,   0);
`else
    chk("dep_off_valid", upd_valid, 0);
`endif
    repeat (3) cyc(1'b1, 8'h00, 1'b0, 1'b1);

    // Backpressure and merge
    do_reset();
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, 8'h00, 1'b0, 1'b0);
      chk("bp_valid", upd_valid, 1);
      chk("bp_idx",   upd_idx,   0);
      chk("bp_dir",   upd_dir,   1);
      chk("bp_merge", merge_cnt, 1);
    end
    xq.delete();
    repeat (6) cyc(1'b1, 8'h00, 1'b0, 1'b1);
    chk("bp_xfers", xq.size(), 1);
    if (xq.size() >= 1) chk("bp_xfer0", xq[0], 1);

    // Reset while a request is outstanding: dropped at once, never replayed
    do_reset();
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    chk("mid_valid_before", upd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", upd_valid, 0);
    chk("mid_busy_async",  busy,      0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    xq.delete();
    repeat (5) cyc(1'b1, 8'h00, 1'b0, 1'b1);
    chk("mid_no_replay", xq.size(), 0);

    // Round-robin after grant at 5, then learn=0 while pending bits drain
    do_reset();
    cyc(1'b1, 8'h20, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h42, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    xq.delete();
    repeat (10) cyc(1'b0, 8'hFF, 1'b1, 1'b1);
    chk("rr_xfers", xq.size(), 3);
    if (xq.size() == 3) begin
      chk("rr_first",  xq[0], 11);
      chk("rr_second", xq[1], 13);
      chk("rr_third",  xq[2], 3);
    end
    chk("rr_merge", merge_cnt, 1);
    chk("rr_idle",  upd_valid, 0);

    // Merge counter saturation
    do_reset();
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (40) cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("sat_merge", merge_cnt, 255);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          8'($urandom & $urandom & $urandom),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
